// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control slice.
//   sw_state_t              run-control FSM state, encoding visible on state_o
//   DEFAULT_DEBOUNCE_CYCLES 10 ms of stable input at 100 MHz
//   DEFAULT_SYNC_STAGES     synchroniser depth per button
//   sw_next                 next-state function of the run-control FSM
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } sw_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEFAULT_SYNC_STAGES     = 2;

  // Pulses are prioritised stop > start > lap; a lower-priority pulse in the
  // same cycle as a higher one is simply dropped.
  function automatic sw_state_t sw_next(input sw_state_t s,
                                        input logic start,
                                        input logic stop,
                                        input logic lap);
    sw_state_t n;
    n = s;
    case (s)
      IDLE: begin
        if (stop)       n = IDLE;
        else if (start) n = RUN;
      end
      RUN: begin
        if (stop)       n = PAUSE;
        else if (start) n = RUN;
        else if (lap)   n = LAP;
      end
      LAP: begin
        if (stop)       n = PAUSE;
        else if (start) n = LAP;
        else if (lap)   n = RUN;
      end
      PAUSE: begin
        if (stop)       n = IDLE;
        else if (start) n = RUN;
      end
      default: n = IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// btn_debounce: conditions one raw push-button.
//   clk100MHz  in  system clock, posedge
//   rst        in  synchronous reset, active high
//   btn_raw    in  asynchronous raw button level
//   btn_level  out debounced button level
//   btn_press  out one-cycle pulse on a debounced 0->1 change
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic clk100MHz,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // Accepting on the increment that would reach DEBOUNCE_CYCLES means the
  // counter never actually holds that value, so it cannot wrap.
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   stable;
  logic                   stable_q;
  logic                   synced;

  assign synced    = sync[SYNC_STAGES-1];
  assign btn_level = stable;

  // Synchroniser, debounce counter and press-edge register. The press pulse
  // comes from a delayed copy of the stable level, which adds one cycle of
  // latency but keeps the pulse a clean registered output.
  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      sync      <= '0;
      cnt       <= '0;
      stable    <= 1'b0;
      stable_q  <= 1'b0;
      btn_press <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], btn_raw};
      if (synced == stable) begin
        cnt <= '0;
      end else if (cnt >= LAST) begin
        stable <= synced;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      stable_q  <= stable;
      btn_press <= stable & ~stable_q;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button conditioning plus run-control FSM feeding the
// stopwatch counter.
//   clk100MHz  in  system clock, posedge
//   rst        in  synchronous reset, active high
//   start_btn  in  raw start button
//   stop_btn   in  raw stop button
//   lap_btn    in  raw lap button
//   count_en   out counter enable (RUN or LAP), registered
//   count_clr  out one-cycle counter clear, registered
//   lap_hold   out display freeze (LAP), registered
//   state_o    out FSM state: IDLE=0 RUN=1 LAP=2 PAUSE=3
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic       clk100MHz,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       lap_btn,
  output logic       count_en,
  output logic       count_clr,
  output logic       lap_hold,
  output logic [1:0] state_o
);

  logic      start_press;
  logic      stop_press;
  logic      lap_press;
  logic [2:0] unused_levels;
  sw_state_t state;
  sw_state_t next;
  logic      clr_req;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_start (
    .clk100MHz(clk100MHz), .rst(rst), .btn_raw(start_btn),
    .btn_level(unused_levels[0]), .btn_press(start_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_stop (
    .clk100MHz(clk100MHz), .rst(rst), .btn_raw(stop_btn),
    .btn_level(unused_levels[1]), .btn_press(stop_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_lap (
    .clk100MHz(clk100MHz), .rst(rst), .btn_raw(lap_btn),
    .btn_level(unused_levels[2]), .btn_press(lap_press)
  );

  // A stop pulse clears the counter whenever it lands the FSM in IDLE, i.e.
  // from IDLE itself or from PAUSE.
  always_comb begin
    next    = sw_next(state, start_press, stop_press, lap_press);
    clr_req = stop_press && ((state == IDLE) || (state == PAUSE));
  end

  // Outputs decode the next state so they change on the same edge as the
  // state register; count_en is low in IDLE, so it never overlaps count_clr.
  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      state     <= IDLE;
      count_en  <= 1'b0;
      count_clr <= 1'b0;
      lap_hold  <= 1'b0;
    end else begin
      state     <= next;
      count_en  <= (next == RUN) || (next == LAP);
      lap_hold  <= (next == LAP);
      count_clr <= clr_req;
    end
  end

  assign state_o = state;

endmodule
